// File: rtl/bit_reverse_pkg.sv
// Shared helpers for the FFT reorder stages: index bit reversal, ceil-log2,
// and the read pipeline stage record used by bit_reverse.
package bit_reverse_pkg;

   localparam int MAX_C_W = 16;
   localparam int IDX_W   = 4;

   typedef logic [MAX_C_W-1:0] addr_t;

   // One in-flight RAM read: valid, frame-start marker and the bank it came from.
   typedef struct packed {
      logic vld;
      logic new_fft;
      logic bank;
   } rd_stage_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   // Reverses the low 'width' bits of index; bits above width come back zero.
   function automatic addr_t bitrev(input addr_t index, input int width);
      addr_t            result;
      logic [IDX_W-1:0] pos;
      result = '0;
      for (int i = 0; i < MAX_C_W; i++) begin
         if (i < width) begin
            pos         = IDX_W'(width - 1 - i);
            result[pos] = index[i[IDX_W-1:0]];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/bitrev_bank_ram.sv
// One ping-pong bank: single-port DEPTH x DATA_W memory with a registered read
// port that only updates when a read is requested.
module bitrev_bank_ram
   import bit_reverse_pkg::*;
#(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 128
)
(
   input  logic                       clk,
   input  logic                       we,
   input  logic                       re,
   input  logic [clog2(DEPTH)-1:0]    addr,
   input  logic [DATA_W-1:0]          wdata,
   output logic [DATA_W-1:0]          rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are never reset; a frame is always fully written before it is read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/bit_reverse.sv
// Ping-pong frame reorderer: natural-order frames in, bit-reversed order out,
// one frame plus two cycles later, rate-matched to i_vld with no backpressure.
module bit_reverse
   import bit_reverse_pkg::*;
#(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 128
)
(
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_init,
   input  logic              i_vld,
   input  logic              i_new_fft,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_vld,
   output logic              o_new_fft,
   output logic [DATA_W-1:0] o_data,
   output logic              o_align_err
);

   localparam int             C_W  = clog2(DEPTH);
   localparam logic [C_W-1:0] LAST = C_W'(DEPTH - 1);

   logic [C_W-1:0]    wp;
   logic              wr_b;
   logic              have_frame;
   rd_stage_t         s1;

   logic              beat;
   logic              realign;
   logic              rd_issue;
   logic              wr_sel;
   logic [C_W-1:0]    wr_addr;
   logic [C_W-1:0]    rd_addr;

   logic [1:0]        bank_we;
   logic [1:0]        bank_re;
   logic [C_W-1:0]    bank_addr  [2];
   logic [DATA_W-1:0] bank_rdata [2];

   assign beat     = i_vld & ~i_init;
   assign realign  = beat & i_new_fft & (wp != '0);
   assign rd_issue = beat & have_frame & ~realign;

   // A realign restarts the frame in bank 0 at index 0 regardless of where we were.
   assign wr_sel   = realign ? 1'b0 : wr_b;
   assign wr_addr  = realign ? '0 : wp;
   assign rd_addr  = C_W'(bitrev(addr_t'(wp), C_W));

   // The read bank is always the one not being written, so the two never collide.
   always_comb begin
      bank_we      = '0;
      bank_re      = '0;
      bank_we[0]   = beat & ~wr_sel;
      bank_we[1]   = beat & wr_sel;
      bank_re[0]   = rd_issue & wr_b;
      bank_re[1]   = rd_issue & ~wr_b;
      bank_addr[0] = wr_sel ? rd_addr : wr_addr;
      bank_addr[1] = wr_sel ? wr_addr : rd_addr;
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      bitrev_bank_ram #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_ram (
         .clk   (clk),
         .we    (bank_we[b]),
         .re    (bank_re[b]),
         .addr  (bank_addr[b]),
         .wdata (i_data),
         .rdata (bank_rdata[b])
      );
   end

   // Write index, bank select and frame-buffered flag.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         wp         <= '0;
         wr_b       <= 1'b0;
         have_frame <= 1'b0;
      end else if (i_init) begin
         wp         <= '0;
         wr_b       <= 1'b0;
         have_frame <= 1'b0;
      end else if (realign) begin
         wp         <= C_W'(1);
         wr_b       <= 1'b0;
         have_frame <= 1'b0;
      end else if (beat) begin
         if (wp == LAST) begin
            wp         <= '0;
            wr_b       <= ~wr_b;
            have_frame <= 1'b1;
         end else begin
            wp <= wp + C_W'(1);
         end
      end
   end

   // Tracks the read that is sitting in a bank's registered output.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         s1 <= '0;
      end else if (i_init) begin
         s1 <= '0;
      end else begin
         s1 <= '{vld: rd_issue, new_fft: rd_issue & (wp == '0), bank: ~wr_b};
      end
   end

   // Output register; o_data only moves on a valid beat so it holds across gaps and i_init.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         o_vld       <= 1'b0;
         o_new_fft   <= 1'b0;
         o_align_err <= 1'b0;
         o_data      <= '0;
      end else if (i_init) begin
         o_vld       <= 1'b0;
         o_new_fft   <= 1'b0;
         o_align_err <= 1'b0;
      end else begin
         o_vld       <= s1.vld;
         o_new_fft   <= s1.new_fft;
         o_align_err <= realign;
         if (s1.vld) begin
            o_data <= s1.bank ? bank_rdata[1] : bank_rdata[0];
         end
      end
   end

endmodule

// File: tb/tb_bit_reverse.sv
// Directed bench for bit_reverse at DEPTH=8: streams, gaps, realign, init and async reset.
module tb_bit_reverse;

   localparam int DATA_W = 20;
   localparam int DEPTH  = 8;

   logic              clk = 1'b0;
   logic              i_rst;
   logic              i_init;
   logic              i_vld;
   logic              i_new_fft;
   logic [DATA_W-1:0] i_data;
   logic              o_vld;
   logic              o_new_fft;
   logic [DATA_W-1:0] o_data;
   logic              o_align_err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int cap_data[$];
   int cap_new[$];
   int cap_cyc[$];
   int align_cyc[$];
   int exp_data[$];
   int exp_cyc[$];

   bit_reverse #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_init      (i_init),
      .i_vld       (i_vld),
      .i_new_fft   (i_new_fft),
      .i_data      (i_data),
      .o_vld       (o_vld),
      .o_new_fft   (o_new_fft),
      .o_data      (o_data),
      .o_align_err (o_align_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One clock of stimulus; outputs are sampled 1ns after the edge and captured.
   task automatic applyStimulus(input logic vld, input logic nf, input logic init, input int data);
      i_vld     = vld;
      i_new_fft = nf;
      i_init    = init;
      i_data    = DATA_W'(data);
      @(posedge clk);
      #1;
      if (o_vld) begin
         cap_data.push_back(int'(o_data));
         cap_new.push_back(int'(o_new_fft));
         cap_cyc.push_back(cyc);
      end
      if (o_align_err) align_cyc.push_back(cyc);
      cyc++;
   endtask

   task automatic clearCapture();
      cap_data.delete();
      cap_new.delete();
      cap_cyc.delete();
      align_cyc.delete();
      exp_data.delete();
      exp_cyc.delete();
      cyc = 0;
   endtask

   task automatic resetDut();
      i_rst     = 1'b1;
      i_init    = 1'b0;
      i_vld     = 1'b0;
      i_new_fft = 1'b0;
      i_data    = '0;
      repeat (2) @(posedge clk);
      #1;
      i_rst = 1'b0;
      clearCapture();
   endtask

   // Compares captured output beats against exp_data/exp_cyc; frame start every DEPTH outputs.
   task automatic compareCapture(input string tag);
      int n;
      checkOutput({tag, "_count"}, cap_data.size(), exp_data.size());
      n = (cap_data.size() < exp_data.size()) ? cap_data.size() : exp_data.size();
      for (int j = 0; j < n; j++) begin
         checkOutput($sformatf("%s_data%0d", tag, j), cap_data[j], exp_data[j]);
         checkOutput($sformatf("%s_new%0d", tag, j), cap_new[j], ((j % DEPTH) == 0) ? 1 : 0);
         checkOutput($sformatf("%s_cyc%0d", tag, j), cap_cyc[j], exp_cyc[j]);
      end
   endtask

   task automatic runTwoFrames(input string tag);
      int pattern[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, (i % 8) == 0, 1'b0, i);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 0);
      for (int j = 0; j < 8; j++) begin
         exp_data.push_back(pattern[j]);
         exp_cyc.push_back(9 + j);
      end
      compareCapture(tag);
   endtask

   initial begin
      int pattern[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      int three[24]  = '{0, 4, 2, 6, 1, 5, 3, 7,
                         8, 12, 10, 14, 9, 13, 11, 15,
                         16, 20, 18, 22, 17, 21, 19, 23};
      int init_seq[8] = '{60, 64, 62, 66, 61, 65, 63, 67};

      i_rst     = 1'b1;
      i_init    = 1'b0;
      i_vld     = 1'b0;
      i_new_fft = 1'b0;
      i_data    = '0;
      #2;
      checkOutput("rst_vld",   32'(o_vld),       0);
      checkOutput("rst_new",   32'(o_new_fft),   0);
      checkOutput("rst_align", 32'(o_align_err), 0);
      checkOutput("rst_data",  32'(o_data),      0);

      $display("[TB] contiguous stream");
      resetDut();
      runTwoFrames("contig");

      $display("[TB] alternating valid");
      resetDut();
      for (int s = 0; s < 32; s++) applyStimulus((s % 2) == 0, (s % 16) == 0, 1'b0, s / 2);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 0);
      for (int j = 0; j < 8; j++) begin
         exp_data.push_back(pattern[j]);
         exp_cyc.push_back(17 + 2 * j);
      end
      compareCapture("gaps");

      $display("[TB] three back-to-back frames");
      resetDut();
      for (int i = 0; i < 32; i++) applyStimulus(1'b1, (i % 8) == 0, 1'b0, i);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 0);
      for (int j = 0; j < 24; j++) begin
         exp_data.push_back(three[j]);
         exp_cyc.push_back(9 + j);
      end
      compareCapture("frames3");

      $display("[TB] realign at wp=3");
      resetDut();
      applyStimulus(1'b1, 1'b1, 1'b0, 10);
      applyStimulus(1'b1, 1'b0, 1'b0, 11);
      applyStimulus(1'b1, 1'b0, 1'b0, 12);
      applyStimulus(1'b1, 1'b1, 1'b0, 100);
      checkOutput("align_pulse", 32'(o_align_err), 1);
      for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 100 + i);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 0);
      checkOutput("align_count", align_cyc.size(), 1);
      if (align_cyc.size() > 0) checkOutput("align_cyc", align_cyc[0], 3);
      exp_data.push_back(100);
      exp_cyc.push_back(12);
      compareCapture("realign");

      $display("[TB] init after read-issuing beat");
      resetDut();
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, (i % 8) == 0, 1'b0, i);
      applyStimulus(1'b1, 1'b0, 1'b1, 50);
      checkOutput("init_vld", 32'(o_vld), 0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, i == 0, 1'b0, 60 + i);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, i == 0, 1'b0, 70 + i);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 0);
      for (int j = 0; j < 8; j++) begin
         exp_data.push_back(init_seq[j]);
         exp_cyc.push_back(19 + j);
      end
      compareCapture("init");

      $display("[TB] asynchronous reset mid-frame");
      resetDut();
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, (i % 8) == 0, 1'b0, i);
      checkOutput("pre_arst_vld",  32'(o_vld),  1);
      checkOutput("pre_arst_data", 32'(o_data), 2);
      #2;
      i_rst = 1'b1;
      #1;
      checkOutput("arst_vld",   32'(o_vld),       0);
      checkOutput("arst_new",   32'(o_new_fft),   0);
      checkOutput("arst_data",  32'(o_data),      0);
      checkOutput("arst_align", 32'(o_align_err), 0);
      i_vld = 1'b0;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      clearCapture();
      runTwoFrames("after_arst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
